// File: rtl/keypad_entry_sequencer.sv
// keypad_entry_sequencer
//   Turns debounced keypad presses into decimal operands for the
//   linear_regression datapath. Each operand is delivered with a one-cycle
//   enter strobe once the datapath is ready. When the full operand set has
//   been entered, a D press issues a single input_done strobe. The block then
//   waits for the datapath result and returns to entry on a C press.
// Ports
//   clk          system clock
//   rst_n        synchronous reset, active low
//   key_code     decoded key: 0-9 digit, C clear, E enter, D done, A/B ignored
//   key_valid    level, high while a key is held
//   ready_in     datapath can accept an operand
//   calc_done    datapath finished (level or pulse)
//   data_out     operand presented to the datapath
//   enter        one-cycle operand strobe
//   input_done   one-cycle end-of-input strobe
//   entry_value  operand under construction (display)
//   entry_count  operands delivered this run
//   state_o      FSM state code (display/debug)
//   err          sticky error flag, cleared by the next accepted press
module keypad_entry_sequencer #(
  parameter int ELEM_WIDTH = 12,
  parameter int N_ENTRIES  = 9,
  parameter int DEBOUNCE   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            key_code,
  input  logic                  key_valid,
  input  logic                  ready_in,
  input  logic                  calc_done,
  output logic [ELEM_WIDTH-1:0] data_out,
  output logic                  enter,
  output logic                  input_done,
  output logic [ELEM_WIDTH-1:0] entry_value,
  output logic [3:0]            entry_count,
  output logic [2:0]            state_o,
  output logic                  err
);

  localparam int DW = ELEM_WIDTH + 4;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [ELEM_WIDTH-1:0] MAX_VAL = {ELEM_WIDTH{1'b1}};
  localparam logic [3:0] KEY_C = 4'hC;
  localparam logic [3:0] KEY_D = 4'hD;
  localparam logic [3:0] KEY_E = 4'hE;

  typedef enum logic [2:0] {
    ENTRY  = 3'd0,
    SEND   = 3'd1,
    FINISH = 3'd2,
    BUSY   = 3'd3,
    RESULT = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [CW-1:0]         deb_cnt_r;
  logic                  press_s;
  logic                  digit_seen_r, digit_seen_s;
  logic [ELEM_WIDTH-1:0] entry_value_r, entry_value_s;
  logic [ELEM_WIDTH-1:0] data_out_r, data_out_s;
  logic [3:0]            entry_count_r, entry_count_s;
  logic                  err_r, err_s;
  logic                  enter_r, enter_s;
  logic                  input_done_r, input_done_s;
  logic [DW-1:0]         prod_s;
  logic                  count_full_s;

  // Debounce counter: counts up while the key is held and saturates at
  // DEBOUNCE, so a held key yields exactly one press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_cnt_r <= {CW{1'b0}};
    end else if (!key_valid) begin
      deb_cnt_r <= {CW{1'b0}};
    end else if (deb_cnt_r != CW'(DEBOUNCE)) begin
      deb_cnt_r <= deb_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      deb_cnt_r <= deb_cnt_r;
    end
  end

  // The press fires on the edge where the counter reaches DEBOUNCE.
  assign press_s      = key_valid && (deb_cnt_r == CW'(DEBOUNCE - 1));
  assign prod_s       = {4'b0000, entry_value_r} * DW'(10) + {{(DW-4){1'b0}}, key_code};
  assign count_full_s = (entry_count_r == 4'(N_ENTRIES));

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    state_s       = state_r;
    digit_seen_s  = digit_seen_r;
    entry_value_s = entry_value_r;
    data_out_s    = data_out_r;
    entry_count_s = entry_count_r;
    err_s         = err_r;
    enter_s       = 1'b0;
    input_done_s  = 1'b0;
    case (state_r)
      ENTRY: begin
        if (press_s) begin
          case (key_code)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
              digit_seen_s = 1'b1;
              if (prod_s > {4'b0000, MAX_VAL}) begin
                entry_value_s = MAX_VAL;
                err_s         = 1'b1;
              end else begin
                entry_value_s = prod_s[ELEM_WIDTH-1:0];
                err_s         = 1'b0;
              end
            end
            KEY_C: begin
              entry_value_s = {ELEM_WIDTH{1'b0}};
              digit_seen_s  = 1'b0;
              err_s         = 1'b0;
            end
            KEY_E: begin
              // A full set refuses further operands; an empty entry is ignored.
              if (count_full_s) begin
                err_s = 1'b1;
              end else if (digit_seen_r) begin
                err_s      = 1'b0;
                data_out_s = entry_value_r;
                state_s    = SEND;
              end else begin
                err_s = 1'b0;
              end
            end
            KEY_D: begin
              if (count_full_s) begin
                err_s   = 1'b0;
                state_s = FINISH;
              end else begin
                err_s = 1'b1;
              end
            end
            default: begin
              err_s = err_r;
            end
          endcase
        end else begin
          state_s = ENTRY;
        end
      end
      SEND: begin
        if (ready_in) begin
          enter_s       = 1'b1;
          entry_count_s = entry_count_r + 4'd1;
          entry_value_s = {ELEM_WIDTH{1'b0}};
          digit_seen_s  = 1'b0;
          state_s       = ENTRY;
        end else begin
          state_s = SEND;
        end
      end
      FINISH: begin
        input_done_s = 1'b1;
        state_s      = BUSY;
      end
      BUSY: begin
        if (calc_done) begin
          state_s = RESULT;
        end else begin
          state_s = BUSY;
        end
      end
      RESULT: begin
        if (press_s && (key_code == KEY_C)) begin
          entry_count_s = 4'd0;
          entry_value_s = {ELEM_WIDTH{1'b0}};
          data_out_s    = {ELEM_WIDTH{1'b0}};
          digit_seen_s  = 1'b0;
          err_s         = 1'b0;
          state_s       = ENTRY;
        end else begin
          state_s = RESULT;
        end
      end
      default: begin
        state_s = ENTRY;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ENTRY;
      digit_seen_r  <= 1'b0;
      entry_value_r <= {ELEM_WIDTH{1'b0}};
      data_out_r    <= {ELEM_WIDTH{1'b0}};
      entry_count_r <= 4'd0;
      err_r         <= 1'b0;
      enter_r       <= 1'b0;
      input_done_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      digit_seen_r  <= digit_seen_s;
      entry_value_r <= entry_value_s;
      data_out_r    <= data_out_s;
      entry_count_r <= entry_count_s;
      err_r         <= err_s;
      enter_r       <= enter_s;
      input_done_r  <= input_done_s;
    end
  end

  assign data_out    = data_out_r;
  assign enter       = enter_r;
  assign input_done  = input_done_r;
  assign entry_value = entry_value_r;
  assign entry_count = entry_count_r;
  assign state_o     = state_r;
  assign err         = err_r;

endmodule

// File: tb/tb_keypad_entry_sequencer.sv
module tb_keypad_entry_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        ready_in;
  logic        calc_done;
  logic [11:0] data_out;
  logic        enter;
  logic        input_done;
  logic [11:0] entry_value;
  logic [3:0]  entry_count;
  logic [2:0]  state_o;
  logic        err;

  int checks = 0;
  int failures = 0;
  int enter_pulses = 0;
  int done_pulses = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_v;

  keypad_entry_sequencer #(.ELEM_WIDTH(12), .N_ENTRIES(9), .DEBOUNCE(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_code(key_code), .key_valid(key_valid),
    .ready_in(ready_in), .calc_done(calc_done), .data_out(data_out),
    .enter(enter), .input_done(input_done), .entry_value(entry_value),
    .entry_count(entry_count), .state_o(state_o), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock; sample 1 time unit after the edge and score any strobes.
  task automatic step();
    @(posedge clk);
    #1;
    checks++;
    assert (!(enter && input_done)) else begin
      failures++;
      $error("FAIL strobe_overlap observed=%0b%0b expected=not both", enter, input_done);
    end
    if (input_done) done_pulses++;
    if (enter) begin
      enter_pulses++;
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_enter observed=%0d expected=no pulse", data_out);
      end
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        chk("enter_data", 32'(data_out), 32'(exp_v));
      end
    end
  endtask

  task automatic press(input logic [3:0] code, input int hold);
    key_code  = code;
    key_valid = 1'b1;
    repeat (hold) step();
    key_valid = 1'b0;
    repeat (2) step();
  endtask

  task automatic digits(input int v);
    int d[$];
    int t;
    t = v;
    do begin
      d.push_front(t % 10);
      t = t / 10;
    end while (t > 0);
    foreach (d[i]) press(4'(d[i]), 6);
  endtask

  initial begin
    rst_n = 1'b0; key_code = 4'd0; key_valid = 1'b0; ready_in = 1'b1; calc_done = 1'b0;
    repeat (3) step();
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_count", 32'(entry_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    step();

    // Operand entry 12 with ready high.
    digits(12);
    chk("val_12", 32'(entry_value), 32'd12);
    exp_q.push_back(12'd12);
    press(4'hE, 6);
    chk("op1_pulses", 32'(enter_pulses), 32'd1);
    chk("op1_count", 32'(entry_count), 32'd1);
    chk("op1_value", 32'(entry_value), 32'd0);

    // Handshake stall.
    ready_in = 1'b0;
    digits(34);
    exp_q.push_back(12'd34);
    press(4'hE, 6);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_state", 32'(state_o), 32'd1);
      chk("stall_data", 32'(data_out), 32'd34);
      chk("stall_no_enter", 32'(enter_pulses), 32'd1);
    end
    ready_in = 1'b1;
    for (int i = 0; i < 10 && enter_pulses < 2; i++) step();
    chk("stall_release", 32'(enter_pulses), 32'd2);
    chk("stall_count", 32'(entry_count), 32'd2);

    // Saturation and clear.
    digits(99999);
    chk("sat_value", 32'(entry_value), 32'd4095);
    chk("sat_err", 32'(err), 32'd1);
    press(4'hC, 6);
    chk("clr_value", 32'(entry_value), 32'd0);
    chk("clr_err", 32'(err), 32'd0);

    // Third operand, then premature D.
    digits(7);
    exp_q.push_back(12'd7);
    press(4'hE, 6);
    chk("op3_count", 32'(entry_count), 32'd3);
    press(4'hD, 6);
    chk("early_d_err", 32'(err), 32'd1);
    chk("early_d_state", 32'(state_o), 32'd0);
    chk("early_d_done", 32'(done_pulses), 32'd0);
    press(4'hE, 6);
    chk("empty_e_pulses", 32'(enter_pulses), 32'd3);
    chk("empty_e_state", 32'(state_o), 32'd0);

    // Long hold counts as a single press.
    press(4'd5, 100);
    chk("hold_value", 32'(entry_value), 32'd5);
    exp_q.push_back(12'd5);
    press(4'hE, 6);

    // Remaining operands of the run.
    for (int v = 100; v < 105; v++) begin
      digits(v);
      exp_q.push_back(12'(v));
      press(4'hE, 6);
    end
    chk("full_count", 32'(entry_count), 32'd9);
    chk("full_pulses", 32'(enter_pulses), 32'd9);
    chk("full_queue", 32'(exp_q.size()), 32'd0);

    // Extra operand refused once the set is full.
    digits(8);
    press(4'hE, 6);
    chk("over_err", 32'(err), 32'd1);
    chk("over_pulses", 32'(enter_pulses), 32'd9);
    press(4'hC, 6);

    // Done, datapath completes, clear for next run.
    press(4'hD, 6);
    chk("done_pulses", 32'(done_pulses), 32'd1);
    chk("busy_state", 32'(state_o), 32'd3);
    press(4'hC, 6);
    chk("busy_drop", 32'(state_o), 32'd3);
    calc_done = 1'b1;
    step();
    calc_done = 1'b0;
    step();
    chk("result_state", 32'(state_o), 32'd4);
    press(4'hC, 6);
    chk("next_state", 32'(state_o), 32'd0);
    chk("next_count", 32'(entry_count), 32'd0);
    chk("next_data", 32'(data_out), 32'd0);
    chk("total_done", 32'(done_pulses), 32'd1);

    // Reset while an operand is waiting in SEND.
    ready_in = 1'b0;
    digits(6);
    press(4'hE, 6);
    chk("presend_state", 32'(state_o), 32'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_state", 32'(state_o), 32'd0);
    chk("midrst_enter", 32'(enter), 32'd0);
    chk("midrst_count", 32'(entry_count), 32'd0);
    chk("midrst_data", 32'(data_out), 32'd0);
    rst_n = 1'b1;
    ready_in = 1'b1;
    repeat (3) step();
    chk("midrst_pulses", 32'(enter_pulses), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
